// File: rtl/sigma_delta_bitstream_gen.sv
// First-order sigma-delta modulator: each accepted sample word becomes an OSR-bit
// frame whose density of ones tracks sample / 2^WIDTH.
module sigma_delta_bitstream_gen #(
  parameter int WIDTH = 16,
  parameter int OSR   = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear_underrun,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             underrun,
  output logic [15:0]      frame_count
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [15:0] OSR_LAST = 16'(OSR - 1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [15:0]      phase_r, phase_s;
  logic [WIDTH-1:0] pend_r, pend_s;
  logic             pend_full_r, pend_full_s;
  logic [WIDTH-1:0] active_r, active_s;
  logic             bit_out_r, bit_out_s;
  logic             bit_valid_r, bit_valid_s;
  logic             frame_start_r, frame_start_s;
  logic             underrun_r, underrun_s;
  logic [15:0]      frame_count_r, frame_count_s;

  logic             xfer_s;
  logic             start_s;
  logic             emit_s;
  logic [WIDTH-1:0] emit_x_s;
  logic [WIDTH-1:0] acc_base_s;
  logic [WIDTH:0]   sum_s;

  assign xfer_s      = in_valid && !pend_full_r;
  assign in_ready    = !pend_full_r;
  assign bit_out     = bit_out_r;
  assign bit_valid   = bit_valid_r;
  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;
  assign frame_count = frame_count_r;

  // Next-state, sample selection and modulator step.
  always_comb begin
    state_s       = state_r;
    acc_s         = acc_r;
    phase_s       = phase_r;
    pend_s        = pend_r;
    pend_full_s   = pend_full_r;
    active_s      = active_r;
    bit_out_s     = 1'b0;
    bit_valid_s   = 1'b0;
    frame_start_s = 1'b0;
    underrun_s    = clear_underrun ? 1'b0 : underrun_r;
    frame_count_s = frame_count_r;
    start_s       = 1'b0;
    emit_s        = 1'b0;
    emit_x_s      = active_r;
    acc_base_s    = acc_r;

    case (state_r)
      ST_IDLE: begin
        // Every frame started from idle runs from a cleared accumulator.
        acc_base_s = {WIDTH{1'b0}};
        if (run && pend_full_r) begin
          start_s     = 1'b1;
          emit_x_s    = pend_r;
          pend_full_s = 1'b0;
        end else if (run && xfer_s) begin
          start_s  = 1'b1;
          emit_x_s = in_data;
        end else if (xfer_s) begin
          pend_s      = in_data;
          pend_full_s = 1'b1;
        end else begin
          pend_full_s = pend_full_r;
        end
      end
      ST_RUN: begin
        // phase_r == 0 in RUN marks the boundary after the last bit of a frame.
        if (phase_r != 16'd0) begin
          emit_s = 1'b1;
          if (xfer_s) begin
            pend_s      = in_data;
            pend_full_s = 1'b1;
          end else begin
            pend_full_s = pend_full_r;
          end
        end else if (!run) begin
          state_s = ST_IDLE;
          if (xfer_s) begin
            pend_s      = in_data;
            pend_full_s = 1'b1;
          end else begin
            pend_full_s = pend_full_r;
          end
        end else if (pend_full_r) begin
          start_s     = 1'b1;
          emit_x_s    = pend_r;
          pend_full_s = 1'b0;
        end else if (in_valid) begin
          start_s  = 1'b1;
          emit_x_s = in_data;
        end else begin
          start_s    = 1'b1;
          emit_x_s   = active_r;
          underrun_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    sum_s = {1'b0, acc_base_s} + {1'b0, emit_x_s};

    if (start_s) begin
      state_s       = ST_RUN;
      active_s      = emit_x_s;
      phase_s       = 16'd1;
      frame_start_s = 1'b1;
      frame_count_s = frame_count_r + 16'd1;
    end else if (emit_s) begin
      phase_s = (phase_r == OSR_LAST) ? 16'd0 : phase_r + 16'd1;
    end else begin
      phase_s = phase_r;
    end

    if (start_s || emit_s) begin
      bit_out_s   = sum_s[WIDTH];
      bit_valid_s = 1'b1;
      acc_s       = sum_s[WIDTH-1:0];
    end else begin
      acc_s = acc_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      acc_r         <= {WIDTH{1'b0}};
      phase_r       <= 16'd0;
      pend_r        <= {WIDTH{1'b0}};
      pend_full_r   <= 1'b0;
      active_r      <= {WIDTH{1'b0}};
      bit_out_r     <= 1'b0;
      bit_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      state_r       <= state_s;
      acc_r         <= acc_s;
      phase_r       <= phase_s;
      pend_r        <= pend_s;
      pend_full_r   <= pend_full_s;
      active_r      <= active_s;
      bit_out_r     <= bit_out_s;
      bit_valid_r   <= bit_valid_s;
      frame_start_r <= frame_start_s;
      underrun_r    <= underrun_s;
      frame_count_r <= frame_count_s;
    end
  end

endmodule

// File: tb/tb_sigma_delta_bitstream_gen.sv
// Directed bench for sigma_delta_bitstream_gen (WIDTH=16, OSR=64) with
// hand-computed bit patterns and ones counts.
module tb_sigma_delta_bitstream_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clear_underrun;
  logic        bit_out;
  logic        bit_valid;
  logic        frame_start;
  logic        underrun;
  logic [15:0] frame_count;

  int checks = 0;
  int passes = 0;

  logic [63:0] bits;
  int          bad;
  logic        rdy1;
  logic        urun1;

  always #5 clk = ~clk;

  sigma_delta_bitstream_gen #(.WIDTH(16), .OSR(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .clear_underrun (clear_underrun),
    .bit_out        (bit_out),
    .bit_valid      (bit_valid),
    .frame_start    (frame_start),
    .underrun       (underrun),
    .frame_count    (frame_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = 16'h0; clear_underrun = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
  endtask

  // Called while bit 0 of a frame is visible; leaves bit 63 visible.
  task automatic count_frame(input bit feed_en, input logic [15:0] feed_data, input bit clr_en,
                             input int drop_idx, output logic [63:0] fbits, output int fbad,
                             output logic frdy1, output logic furun1);
    fbits = 64'h0; fbad = 0; frdy1 = 1'bx; furun1 = 1'bx;
    fbits[0] = bit_out;
    if (bit_valid !== 1'b1 || frame_start !== 1'b1) fbad++;
    if (feed_en) begin in_valid = 1'b1; in_data = feed_data; end
    if (clr_en) clear_underrun = 1'b1;
    for (int i = 1; i < 64; i++) begin
      if (i == drop_idx) run = 1'b0;
      tick;
      if (i == 1) begin
        in_valid = 1'b0; clear_underrun = 1'b0;
        frdy1 = in_ready; furun1 = underrun;
      end
      fbits[i] = bit_out;
      if (bit_valid !== 1'b1 || frame_start !== 1'b0) fbad++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = 16'h0; clear_underrun = 1'b0;
    #2;
    checks++; if ({bit_out, bit_valid, frame_start, underrun} !== 4'b0000) $display("FAIL reset_outs: got %b want 0000", {bit_out, bit_valid, frame_start, underrun}); else passes++;
    checks++; if (frame_count !== 16'd0) $display("FAIL reset_fc: got %0d want 0", frame_count); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_rdy: got %b want 1", in_ready); else passes++;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_half_scale;
    do_reset;
    run = 1'b1; in_valid = 1'b1; in_data = 16'h8000;
    tick;
    in_valid = 1'b0;
    checks++; if (bit_valid !== 1'b1 || frame_start !== 1'b1) $display("FAIL half_latency: got bv=%b fs=%b want 1 1", bit_valid, frame_start); else passes++;
    checks++; if (frame_count !== 16'd1) $display("FAIL half_fc: got %0d want 1", frame_count); else passes++;
    count_frame(1'b0, 16'h0, 1'b0, -1, bits, bad, rdy1, urun1);
    checks++; if (bits !== 64'hAAAA_AAAA_AAAA_AAAA) $display("FAIL half_bits: got %h want aaaaaaaaaaaaaaaa", bits); else passes++;
    checks++; if ($countones(bits) !== 32) $display("FAIL half_ones: got %0d want 32", $countones(bits)); else passes++;
    checks++; if (bad !== 0) $display("FAIL half_framing: got %0d bad bits want 0", bad); else passes++;
  endtask

  task automatic test_back_to_back;
    do_reset;
    run = 1'b1; in_valid = 1'b1; in_data = 16'h0000;
    tick;
    count_frame(1'b1, 16'hFFFF, 1'b0, -1, bits, bad, rdy1, urun1);
    checks++; if (rdy1 !== 1'b0) $display("FAIL b2b_rdy_full: got %b want 0", rdy1); else passes++;
    checks++; if ($countones(bits) !== 0 || bad !== 0) $display("FAIL b2b_f1: got ones=%0d bad=%0d want 0 0", $countones(bits), bad); else passes++;
    tick;
    checks++; if (frame_start !== 1'b1 || bit_valid !== 1'b1) $display("FAIL b2b_contig2: got fs=%b bv=%b want 1 1", frame_start, bit_valid); else passes++;
    count_frame(1'b1, 16'h4000, 1'b0, -1, bits, bad, rdy1, urun1);
    checks++; if ($countones(bits) !== 63 || bad !== 0) $display("FAIL b2b_f2: got ones=%0d bad=%0d want 63 0", $countones(bits), bad); else passes++;
    tick;
    checks++; if (frame_start !== 1'b1 || frame_count !== 16'd3) $display("FAIL b2b_contig3: got fs=%b fc=%0d want 1 3", frame_start, frame_count); else passes++;
    count_frame(1'b0, 16'h0, 1'b0, -1, bits, bad, rdy1, urun1);
    checks++; if ($countones(bits) !== 16 || bad !== 0) $display("FAIL b2b_f3: got ones=%0d bad=%0d want 16 0", $countones(bits), bad); else passes++;
    checks++; if (underrun !== 1'b0) $display("FAIL b2b_underrun: got %b want 0", underrun); else passes++;
  endtask

  task automatic test_underrun;
    do_reset;
    run = 1'b1; in_valid = 1'b1; in_data = 16'h4000;
    tick;
    in_valid = 1'b0;
    count_frame(1'b0, 16'h0, 1'b0, -1, bits, bad, rdy1, urun1);
    checks++; if (bits !== 64'h8888_8888_8888_8888) $display("FAIL ur_f1_bits: got %h want 8888888888888888", bits); else passes++;
    checks++; if (underrun !== 1'b0) $display("FAIL ur_before: got %b want 0", underrun); else passes++;
    tick;
    checks++; if (underrun !== 1'b1 || frame_start !== 1'b1 || frame_count !== 16'd2) $display("FAIL ur_repeat: got ur=%b fs=%b fc=%0d want 1 1 2", underrun, frame_start, frame_count); else passes++;
    count_frame(1'b0, 16'h0, 1'b1, -1, bits, bad, rdy1, urun1);
    checks++; if (urun1 !== 1'b0) $display("FAIL ur_clear: got %b want 0", urun1); else passes++;
    checks++; if ($countones(bits) !== 16 || bad !== 0) $display("FAIL ur_f2: got ones=%0d bad=%0d want 16 0", $countones(bits), bad); else passes++;
    tick;
    checks++; if (underrun !== 1'b1 || frame_count !== 16'd3) $display("FAIL ur_reset: got ur=%b fc=%0d want 1 3", underrun, frame_count); else passes++;
  endtask

  task automatic test_boundary_bypass;
    do_reset;
    run = 1'b1; in_valid = 1'b1; in_data = 16'h8000;
    tick;
    in_valid = 1'b0;
    count_frame(1'b0, 16'h0, 1'b0, -1, bits, bad, rdy1, urun1);
    in_valid = 1'b1; in_data = 16'hC000;
    tick;
    in_valid = 1'b0;
    checks++; if (frame_start !== 1'b1 || underrun !== 1'b0 || frame_count !== 16'd2) $display("FAIL byp_start: got fs=%b ur=%b fc=%0d want 1 0 2", frame_start, underrun, frame_count); else passes++;
    count_frame(1'b0, 16'h0, 1'b0, -1, bits, bad, rdy1, urun1);
    checks++; if (bits !== 64'hEEEE_EEEE_EEEE_EEEE) $display("FAIL byp_bits: got %h want eeeeeeeeeeeeeeee", bits); else passes++;
    checks++; if ($countones(bits) !== 48 || underrun !== 1'b0) $display("FAIL byp_ones: got ones=%0d ur=%b want 48 0", $countones(bits), underrun); else passes++;
  endtask

  task automatic test_run_stop;
    do_reset;
    run = 1'b1; in_valid = 1'b1; in_data = 16'h3FFF;
    tick;
    in_valid = 1'b0;
    count_frame(1'b0, 16'h0, 1'b0, 10, bits, bad, rdy1, urun1);
    checks++; if ($countones(bits) !== 15 || bad !== 0) $display("FAIL stop_f1: got ones=%0d bad=%0d want 15 0", $countones(bits), bad); else passes++;
    tick;
    checks++; if (bit_valid !== 1'b0 || bit_out !== 1'b0 || frame_count !== 16'd1) $display("FAIL stop_idle: got bv=%b bo=%b fc=%0d want 0 0 1", bit_valid, bit_out, frame_count); else passes++;
    in_valid = 1'b1; in_data = 16'h4000;
    tick;
    in_valid = 1'b0;
    tick; tick;
    checks++; if (in_ready !== 1'b0 || bit_valid !== 1'b0) $display("FAIL stop_pend: got rdy=%b bv=%b want 0 0", in_ready, bit_valid); else passes++;
    run = 1'b1;
    tick;
    checks++; if (frame_start !== 1'b1 || in_ready !== 1'b1 || frame_count !== 16'd2) $display("FAIL stop_restart: got fs=%b rdy=%b fc=%0d want 1 1 2", frame_start, in_ready, frame_count); else passes++;
    count_frame(1'b0, 16'h0, 1'b0, -1, bits, bad, rdy1, urun1);
    checks++; if (bits !== 64'h8888_8888_8888_8888) $display("FAIL stop_acc_clr: got %h want 8888888888888888", bits); else passes++;
  endtask

  task automatic test_reset_mid_frame;
    do_reset;
    run = 1'b1; in_valid = 1'b1; in_data = 16'h8000;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    reset_n = 1'b0;
    #1;
    checks++; if ({bit_out, bit_valid, frame_start, underrun} !== 4'b0000 || frame_count !== 16'd0) $display("FAIL rst_mid: got %b fc=%0d want 0000 0", {bit_out, bit_valid, frame_start, underrun}, frame_count); else passes++;
    tick;
    reset_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h8000;
    tick;
    in_valid = 1'b0;
    count_frame(1'b0, 16'h0, 1'b0, -1, bits, bad, rdy1, urun1);
    checks++; if (bits !== 64'hAAAA_AAAA_AAAA_AAAA || frame_count !== 16'd1) $display("FAIL rst_again: got %h fc=%0d want aaaaaaaaaaaaaaaa 1", bits, frame_count); else passes++;
  endtask

  initial begin
    test_reset;
    test_half_scale;
    test_back_to_back;
    test_underrun;
    test_boundary_bypass;
    test_run_stop;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
